countdown_timer_ctrl: RTL

Programmable countdown timer controller built around a loadable WIDTH-bit down counter. It accepts a start request with a load value and decrements once every PRESCALE clocks. It supports pause and abort, and signals completion with a single-cycle done pulse. It sits upstream of count consumers: `step` is the per-decrement enable for downstream counters, and `q` feeds display/compare logic.

---
 rtl/countdown_timer_ctrl_if.sv | 25 ++
 rtl/countdown_timer_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/countdown_timer_ctrl_if.sv
// Timer control/status bundle: start/load/pause/abort in; count, step, busy, done, state out.
// The master side drives the requests; the slave side is the timer itself.
interface countdown_timer_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] q;
    logic             step;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        output start, load_val, pause, abort,
        input  q, step, busy, done, state
    );

    modport slave (
        input  start, load_val, pause, abort,
        output q, step, busy, done, state
    );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// Loadable down-counter timer: one decrement every PRESCALE clocks, pause/abort, 1-cycle done.
// Outputs are register-decoded (one edge from request to effect); no backpressure, start ignored while busy.
module countdown_timer_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    countdown_timer_ctrl_if.slave tmr
);
    localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10,
        S_DONE = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [PCW-1:0]   pc_q, pc_d;
    logic             step_q, step_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        step_d  = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
                // A zero load completes immediately without ever entering RUN.
                if (tmr.start) begin
                    if (tmr.load_val != '0) begin
                        cnt_d   = tmr.load_val;
                        pc_d    = '0;
                        state_d = S_RUN;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end
                end
            end

            S_RUN: begin
                if (tmr.abort) begin
                    cnt_d   = '0;
                    pc_d    = '0;
                    state_d = S_IDLE;
                end else if (tmr.pause) begin
                    state_d = S_HOLD;
                end else if (pc_q == PC_LAST) begin
                    pc_d   = '0;
                    cnt_d  = cnt_q - WIDTH'(1);
                    step_d = 1'b1;
                    if (cnt_q == WIDTH'(1)) begin
                        state_d = S_DONE;
                    end
                end else begin
                    pc_d = (PRESCALE == 1) ? '0 : pc_q + PCW'(1);
                end
            end

            S_HOLD: begin
                if (tmr.abort) begin
                    cnt_d   = '0;
                    pc_d    = '0;
                    state_d = S_IDLE;
                end else if (!tmr.pause) begin
                    state_d = S_RUN;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign tmr.q     = cnt_q;
    assign tmr.step  = step_q;
    assign tmr.busy  = (state_q == S_RUN) || (state_q == S_HOLD);
    assign tmr.done  = (state_q == S_DONE);
    assign tmr.state = state_q;
endmodule
